// File: rtl/mem_host_ctrl_pkg.sv
// Shared definitions for the host-side memory-access sequencer.
// Contents:
//   host_state_e  sequencer states
//   ST_*          processor status codes, shared with the processor and its control block
//   dump_addr()   16-bit wrapping address for the dump window
package mem_host_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDumpAddr,
        StDumpOut,
        StDone
    } host_state_e;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;
    localparam logic [1:0] ST_READ  = 2'b11;

    // The dump window may straddle the top of the address space; wrap mod 2^16.
    function automatic logic [15:0] dump_addr(input logic [15:0] base, input logic [15:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/mem_host_ctrl_if.sv
// Bundle of every non-clock signal around the host sequencer.
// Signal groups:
//   command     start, load_len, dump_base, dump_len, busy, done, error
//   load stream in_data, in_valid, in_ready
//   dump stream out_data, out_valid, out_ready
//   processor   status, data_in, data_addr_in, dm_out, end_process
// Modports:
//   master  the sequencer (drives status/data/handshake outputs)
//   slave   the environment (host, byte streams, processor)
interface mem_host_ctrl_if;

    logic        start;
    logic [15:0] load_len;
    logic [15:0] dump_base;
    logic [15:0] dump_len;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic [1:0]  status;
    logic [7:0]  data_in;
    logic [15:0] data_addr_in;
    logic [7:0]  dm_out;
    logic        end_process;

    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  start, load_len, dump_base, dump_len,
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        output status, data_in, data_addr_in,
        input  dm_out, end_process,
        output busy, done, error
    );

    modport slave (
        output start, load_len, dump_base, dump_len,
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        input  status, data_in, data_addr_in,
        output dm_out, end_process,
        input  busy, done, error
    );

endinterface

// File: rtl/host_lat_ctr.sv
// Loadable down-counter with a terminal indication.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   load      load load_val (takes priority over counting)
//   load_val  value to load
//   en        count enable
//   tc        high in an enabled cycle whose count is zero
// Loading N gives tc in the (N+1)-th enabled cycle after the load.
module host_lat_ctr #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && count_q != '0) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign tc = en && (count_q == '0);

endmodule

// File: rtl/mem_host_ctrl.sv
// Host-side sequencer for the processor's external memory-access pins.
// One transaction per start: LOAD a byte image into data memory from address 0,
// RUN the processor until end_process (or timeout), then DUMP a window back out.
// Parameters:
//   RD_LAT   cycles from status=11 + address driven to dm_out valid
//   TIMEOUT  max RUN cycles before abort, 0 disables
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  mem_host_ctrl_if.master: command, load/dump streams, processor pins
// All outputs are registered.
module mem_host_ctrl
    import mem_host_ctrl_pkg::*;
#(
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    mem_host_ctrl_if.master   bus
);

    localparam logic [31:0] RdLatVal   = 32'(RD_LAT);
    localparam logic [31:0] TimeoutVal = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    host_state_e state_q;
    logic [1:0]  status_q;
    logic [7:0]  data_in_q;
    logic [15:0] data_addr_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic [15:0] cnt_q;
    logic [15:0] load_len_q;
    logic [15:0] dump_base_q;
    logic [15:0] dump_len_q;

    logic [15:0] cnt_nxt;
    logic        out_hs;
    logic        lat_load;
    logic [31:0] lat_val;
    logic        lat_en;
    logic        lat_tc;

    assign cnt_nxt = cnt_q + 16'd1;
    assign out_hs  = out_valid_q && bus.out_ready;

    // One counter serves both the RUN timeout and the read-latency wait;
    // the two uses never overlap.
    always_comb begin
        lat_load = 1'b0;
        lat_val  = TimeoutVal;
        unique case (state_q)
            StIdle:    lat_load = bus.start && (bus.load_len == 16'd0);
            StLoad:    lat_load = !in_ready_q;
            StRun: begin
                lat_load = bus.end_process && (dump_len_q != 16'd0);
                lat_val  = RdLatVal;
            end
            StDumpOut: begin
                lat_load = out_hs && (cnt_nxt != dump_len_q);
                lat_val  = RdLatVal;
            end
            default: ;
        endcase
    end

    assign lat_en = ((state_q == StRun) && (TIMEOUT != 0)) || (state_q == StDumpAddr);

    host_lat_ctr #(
        .Width (32)
    ) u_lat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .load_val (lat_val),
        .en       (lat_en),
        .tc       (lat_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            status_q    <= ST_IDLE;
            data_in_q   <= '0;
            data_addr_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cnt_q       <= '0;
            load_len_q  <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    status_q    <= ST_IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    if (bus.start) begin
                        load_len_q  <= bus.load_len;
                        dump_base_q <= bus.dump_base;
                        dump_len_q  <= bus.dump_len;
                        error_q     <= 1'b0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        if (bus.load_len != 16'd0) begin
                            state_q    <= StLoad;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q  <= StRun;
                            status_q <= ST_RUN;
                        end
                    end
                end

                StLoad: begin
                    if (!in_ready_q) begin
                        // Last byte's write cycle has just completed.
                        state_q  <= StRun;
                        status_q <= ST_RUN;
                    end else if (bus.in_valid) begin
                        data_in_q   <= bus.in_data;
                        data_addr_q <= cnt_q;
                        status_q    <= ST_WRITE;
                        cnt_q       <= cnt_nxt;
                        in_ready_q  <= (cnt_nxt != load_len_q);
                    end else begin
                        // No accept: drop out of write mode so stale data is not rewritten.
                        status_q <= ST_IDLE;
                    end
                end

                StRun: begin
                    status_q <= ST_RUN;
                    if (bus.end_process) begin
                        cnt_q <= '0;
                        if (dump_len_q == 16'd0) begin
                            state_q  <= StDone;
                            status_q <= ST_IDLE;
                            done_q   <= 1'b1;
                        end else begin
                            state_q     <= StDumpAddr;
                            status_q    <= ST_READ;
                            data_addr_q <= dump_base_q;
                        end
                    end else if (lat_tc) begin
                        error_q  <= 1'b1;
                        state_q  <= StDone;
                        status_q <= ST_IDLE;
                        done_q   <= 1'b1;
                    end
                end

                StDumpAddr: begin
                    if (lat_tc) begin
                        out_data_q  <= bus.dm_out;
                        out_valid_q <= 1'b1;
                        state_q     <= StDumpOut;
                    end
                end

                StDumpOut: begin
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= cnt_nxt;
                        if (cnt_nxt == dump_len_q) begin
                            state_q  <= StDone;
                            status_q <= ST_IDLE;
                            done_q   <= 1'b1;
                        end else begin
                            state_q     <= StDumpAddr;
                            data_addr_q <= dump_addr(dump_base_q, cnt_nxt);
                        end
                    end
                end

                StDone: begin
                    status_q <= ST_IDLE;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.status       = status_q;
    assign bus.data_in      = data_in_q;
    assign bus.data_addr_in = data_addr_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_mem_host_ctrl.sv
// Directed bench for mem_host_ctrl: load with gaps, run/dump with backpressure,
// address wrap, zero lengths, mid-load reset (TIMEOUT=0 instance) and RUN timeout
// (TIMEOUT=8 instance). A small processor model supplies dm_out two cycles after
// status/address and logs every data-memory write.
module tb_mem_host_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_host_ctrl_if bus();
    mem_host_ctrl_if bus_to();

    mem_host_ctrl #(
        .RD_LAT  (2),
        .TIMEOUT (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_host_ctrl #(
        .RD_LAT  (2),
        .TIMEOUT (8)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus_to)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read-only contents of data memory as seen through dm_out.
    function automatic logic [7:0] dm_rd(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h5A;
            16'h0011: return 8'h3C;
            16'hFFFF: return 8'hE7;
            16'h0000: return 8'h19;
            default:  return 8'h00;
        endcase
    endfunction

    // Processor model: registers the address, then a registered memory read.
    logic [15:0] rd_addr_q;
    always @(posedge clk) begin
        rd_addr_q  <= bus.data_addr_in;
        bus.dm_out <= dm_rd(rd_addr_q);
    end

    logic [23:0] wr_log[$];
    always @(posedge clk) begin
        if (!rst && bus.status == 2'b10) wr_log.push_back({bus.data_addr_in, bus.data_in});
    end

    logic read_seen_to = 1'b0;
    always @(posedge clk) begin
        if (bus_to.status == 2'b11) read_seen_to <= 1'b1;
    end

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic        v_valid [6];
    logic [7:0]  v_data  [6];
    int          n;

    initial begin
        v_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        v_data  = '{8'hA1, 8'h00, 8'hB2, 8'h00, 8'h00, 8'hC3};

        bus.start = 1'b0;     bus.load_len = '0;  bus.dump_base = '0;  bus.dump_len = '0;
        bus.in_data = '0;     bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.end_process = 1'b0;
        bus_to.start = 1'b0;  bus_to.load_len = '0; bus_to.dump_base = '0; bus_to.dump_len = '0;
        bus_to.in_data = '0;  bus_to.in_valid = 1'b0; bus_to.out_ready = 1'b0;
        bus_to.end_process = 1'b0; bus_to.dm_out = '0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_status", 32'(bus.status), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_error", 32'(bus.error), 0);
        check("rst_out", 32'({bus.out_valid, bus.out_data}), 0);
        check("rst_dm_pins", 32'({bus.data_addr_in, bus.data_in}), 0);

        // LOAD of 3 bytes with valid gaps
        bus.load_len = 16'd3; bus.dump_base = 16'h0010; bus.dump_len = 16'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ld_in_ready", 32'(bus.in_ready), 1);
        check("ld_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = v_valid[i];
            bus.in_data  = v_data[i];
            step();
            if (v_valid[i]) check("ld_status_wr", 32'(bus.status), 2);
            else            check("ld_status_gap", 32'(bus.status), 0);
        end
        bus.in_valid = 1'b0;
        check("ld_last_in_ready", 32'(bus.in_ready), 0);
        step();
        check("ld_to_run", 32'(bus.status), 1);
        check("ld_wr_count", 32'(wr_log.size()), 3);
        check("ld_wr0", 32'(wr_log[0]), 32'h0000A1);
        check("ld_wr1", 32'(wr_log[1]), 32'h0001B2);
        check("ld_wr2", 32'(wr_log[2]), 32'h0002C3);

        // RUN: in_valid and start ignored; end_process 20 cycles in
        bus.in_valid = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i == 4) begin
                bus.start = 1'b1;
                bus.dump_base = 16'hFFFF;
            end
            if (i == 5) bus.start = 1'b0;
            step();
        end
        check("run_status", 32'(bus.status), 1);
        check("run_in_ready", 32'(bus.in_ready), 0);
        bus.end_process = 1'b1;
        step();
        bus.end_process = 1'b0;
        bus.in_valid = 1'b0;
        check("run_no_wr", 32'(wr_log.size()), 3);
        check("dump0_status", 32'(bus.status), 3);
        check("dump0_addr", 32'(bus.data_addr_in), 32'h0010);

        // DUMP with backpressure on the first byte
        wait_out_valid(n);
        check("dump0_lat", 32'(n), 3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", 32'({bus.out_valid, bus.out_data, bus.data_addr_in}), 32'h15A0010);
        end
        bus.out_ready = 1'b1;
        step();
        check("dump1_hs", 32'(bus.out_valid), 0);
        check("dump1_addr", 32'({bus.status, bus.data_addr_in}), 32'h30011);
        wait_out_valid(n);
        check("dump1_lat", 32'(n), 3);
        check("dump1_data", 32'(bus.out_data), 32'h3C);
        step();
        check("dump_done", 32'({bus.done, bus.busy, bus.status, bus.out_valid}), 32'b11000);
        step();
        check("dump_idle", 32'({bus.done, bus.busy}), 0);
        bus.out_ready = 1'b0;

        // Wrap: dump_base=0xFFFF, dump_len=2, no load
        bus.load_len = 16'd0; bus.dump_base = 16'hFFFF; bus.dump_len = 16'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("wr_run", 32'(bus.status), 1);
        bus.end_process = 1'b1;
        step();
        bus.end_process = 1'b0;
        bus.out_ready = 1'b1;
        check("wrap_addr0", 32'(bus.data_addr_in), 32'hFFFF);
        wait_out_valid(n);
        check("wrap_data0", 32'(bus.out_data), 32'hE7);
        step();
        check("wrap_addr1", 32'(bus.data_addr_in), 32'h0000);
        wait_out_valid(n);
        check("wrap_data1", 32'(bus.out_data), 32'h19);
        step();
        check("wrap_done", 32'(bus.done), 1);
        step();
        bus.out_ready = 1'b0;

        // Timeout on the TIMEOUT=8 instance
        bus_to.load_len = 16'd0; bus_to.dump_len = 16'd2; bus_to.start = 1'b1;
        step();
        bus_to.start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("to_before", 32'({bus_to.error, bus_to.status}), 32'b001);
        step();
        check("to_fire", 32'({bus_to.error, bus_to.done, bus_to.status}), 32'b1100);
        step();
        check("to_sticky", 32'({bus_to.error, bus_to.done, bus_to.busy}), 32'b100);
        check("to_no_dump", 32'(read_seen_to), 0);
        bus_to.start = 1'b1;
        step();
        bus_to.start = 1'b0;
        check("to_clear", 32'({bus_to.error, bus_to.busy}), 32'b01);

        // Reset mid-LOAD after one byte
        bus.load_len = 16'd4; bus.dump_len = 16'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h44;
        step();
        check("rl_write", 32'({bus.status, bus.data_addr_in, bus.data_in}), 32'h2_0000_44);
        rst = 1'b1;
        step();
        check("rl_reset", 32'({bus.status, bus.in_ready, bus.busy}), 0);
        rst = 1'b0;
        step();
        step();
        check("rl_idle", 32'({bus.status, bus.in_ready, bus.busy}), 0);
        check("rl_no_wr", 32'(wr_log.size()), 3);
        bus.in_valid = 1'b0;

        // Zero lengths: IDLE -> RUN -> DONE
        bus.load_len = 16'd0; bus.dump_len = 16'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("zl_run", 32'({bus.status, bus.in_ready}), 32'b010);
        bus.end_process = 1'b1;
        step();
        bus.end_process = 1'b0;
        check("zl_done", 32'({bus.done, bus.status, bus.out_valid}), 32'b1000);
        step();
        check("zl_idle", 32'({bus.busy, bus.done}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
